// File: rtl/boa_mem_responder.sv
// Word-addressed RAM responder for boa_mem_bus with programmable wait states
// and saturating completed-read/write counters.
module boa_mem_responder #(
    parameter int    ALEN      = 16,
    parameter int    DEPTH_LOG = 10,
    parameter string INIT_FILE = ""
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            re_i,
    input  logic [3:0]      we_i,
    input  logic [ALEN-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    output logic            ready_o,
    output logic [31:0]     rdata_o,
    input  logic [3:0]      wait_cyc_i,
    output logic            busy_o,
    output logic [31:0]     rd_count_o,
    output logic [31:0]     wr_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  lat_re_q;
    logic [3:0]            lat_we_q;
    logic [ALEN-1:0]       lat_addr_q;
    logic [31:0]           lat_wdata_q;
    logic                  latch_en;
    logic                  ready;
    logic                  done;
    logic                  req;
    logic                  match;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_count_q;
    logic [31:0]           wr_count_q;
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG-1:0]  idx;
    logic                  unused_addr;

    assign req         = re_i | (|we_i);
    assign idx         = addr_i[DEPTH_LOG+1:2];
    assign unused_addr = ^{addr_i[1:0], addr_i[ALEN-1:DEPTH_LOG+2]};
    assign match       = (re_i == lat_re_q) && (we_i == lat_we_q) &&
                         (addr_i == lat_addr_q) && (wdata_i == lat_wdata_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        done     = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wait_cyc_i == 4'd0) begin
                    ready = 1'b1;
                    done  = req;
                end else if (req) begin
                    latch_en = 1'b1;
                    cnt_d    = wait_cyc_i - 4'd1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (req && match) begin
                    if (cnt_q == 4'd0) begin
                        ready   = 1'b1;
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    // Withdrawn: the new request is judged from IDLE next cycle.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset forces the IDLE view of ready and blocks any access in flight.
    assign ready_o = rst_i ? (wait_cyc_i == 4'd0) : ready;
    assign rd_fire = done & ~rst_i & re_i;
    assign wr_fire = done & ~rst_i & (|we_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            lat_re_q    <= 1'b0;
            lat_we_q    <= 4'd0;
            lat_addr_q  <= '0;
            lat_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            rd_count_q  <= 32'd0;
            wr_count_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                lat_re_q    <= re_i;
                lat_we_q    <= we_i;
                lat_addr_q  <= addr_i;
                lat_wdata_q <= wdata_i;
            end
            if (rd_fire) begin
                rdata_q <= mem_q[idx];
            end
            if (rd_fire && (rd_count_q != 32'hFFFF_FFFF)) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (wr_fire && (wr_count_q != 32'hFFFF_FFFF)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign busy_o     = (state_q == ST_WAIT);
    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;

endmodule
